sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 8, SRAM address width.
REQ-002 The block SHALL have parameter WORD_SIZE, default 4, SRAM data width.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 1, legal range 1..15, number of cycles the SRAM access phase lasts.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit, request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit, controller can accept a request.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_SIZE bits, request address.
REQ-010 The block SHALL have port req_wdata, input, WORD_SIZE bits, write data.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit, one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_we, output, 1 bit, copy of req_we for the completed request.
REQ-013 The block SHALL have port rsp_rdata, output, WORD_SIZE bits, read data; holds its last value otherwise.
REQ-014 The block SHALL have port sram_a, output, ADDR_SIZE bits, drives the SRAM A.
REQ-015 The block SHALL have port sram_d, output, WORD_SIZE bits, drives the SRAM D.
REQ-016 The block SHALL have port sram_wen, output, 1 bit, drives the SRAM WEN (active low).
REQ-017 The block SHALL have port sram_q, input, WORD_SIZE bits, from the SRAM Q (asynchronous, about 2 ns delay).

Function
REQ-018 The block SHALL implement FSM states IDLE, SETUP, ACCESS and HOLD.
REQ-019 req_ready SHALL be 1 only when state = IDLE and rst = 0.
REQ-020 A request SHALL be accepted on an edge where req_valid = 1 and req_ready = 1; on that edge it latches req_we, req_addr and req_wdata into sram_a, sram_d and a we register, and moves to SETUP.
REQ-021 SETUP SHALL last 1 cycle with sram_wen = 1 and sram_a/sram_d stable; then go to ACCESS with the wait counter loaded to WAIT_CYCLES-1.
REQ-022 ACCESS SHALL last exactly WAIT_CYCLES cycles.
REQ-023 In ACCESS, sram_wen SHALL be 0 for writes and 1 for reads.
REQ-024 At the edge leaving ACCESS, a read SHALL register sram_q into rsp_rdata.
REQ-025 HOLD SHALL last 1 cycle with sram_wen = 1, sram_a/sram_d unchanged, rsp_valid = 1 and rsp_we = latched we; then return to IDLE.
REQ-026 sram_a and sram_d SHALL change only on edges where sram_wen is 1 before and after the edge (address/data never move while WEN is low).
REQ-027 sram_wen, rsp_valid and rsp_rdata SHALL be driven from flops (no combinational glitches to the SRAM).
REQ-028 Request-to-response latency SHALL be: accept edge E0; rsp_valid high in cycle WAIT_CYCLES+2 after E0; req_ready high again in the following cycle.
REQ-029 Throughput SHALL be at most 1 request per WAIT_CYCLES+3 cycles.
REQ-030 req_* inputs SHALL be ignored outside IDLE.
REQ-031 A write SHALL leave rsp_rdata unchanged.
REQ-032 For the 1-cycle access case (WAIT_CYCLES = 1), the counter SHALL never underflow.

Reset
REQ-033 On any edge with rst = 1: state = IDLE, sram_wen = 1, rsp_valid = 0, rsp_we = 0, rsp_rdata = 0.
REQ-034 On an edge with rst = 1, sram_a and sram_d SHALL be cleared to 0 only if sram_wen was already 1 before that edge; otherwise they hold.
REQ-035 After rst held for 2 or more edges, all outputs SHALL be 0 except sram_wen = 1.
REQ-036 Reset during a write ACCESS SHALL abort it: WEN rises first, address/data clear one edge later, and no rsp_valid is generated.
REQ-037 A request presented while rst = 1 SHALL NOT be accepted.

Verification
REQ-038 Directed test, reset: rst high 3 cycles -> sram_wen = 1, sram_a = 0, sram_d = 0, req_ready = 0 during reset; req_ready = 1 the cycle after rst falls.
REQ-039 Directed test, write then read (WAIT_CYCLES = 1): write addr 0x3C data 0xA -> sram_wen low exactly 1 cycle with sram_a = 0x3C; read 0x3C -> rsp_valid 3 cycles after accept, rsp_rdata = 0xA, rsp_we = 0.
REQ-040 Directed test, WAIT_CYCLES = 4: write 0xFF/0x5 -> sram_wen low exactly 4 cycles; sram_a stable from SETUP through HOLD; read back 0x5, 6 cycles after accept.
REQ-041 Directed test, back-to-back: req_valid held high with 3 queued requests (W 0x00/0x1, W 0xFF/0xE, R 0x00) -> each accepted only when req_ready = 1, no overlap, read returns 0x1 (address wrap extremes intact).
REQ-042 Directed test, abort: rst asserted in the write ACCESS cycle to 0x10/0x7 -> sram_wen = 1 next edge, sram_a = 0 the edge after, no rsp_valid.
REQ-043 Directed test, ignored request: req_addr/req_wdata toggled while busy -> SRAM pins and the response unaffected; sram_a never changes while sram_wen = 0 (assertion across all tests).

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port synchronous SRAM access sequencer.
// Each request runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> IDLE.
// Address and data only move while WEN is high, so a write strobe always
// sees stable A/D pins. WEN, the response pulse and the read data come
// straight from flops so no combinational glitch ever reaches the SRAM.
module sram_ctrl #(
  parameter int ADDR_SIZE   = 8,
  parameter int WORD_SIZE   = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_we,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic [ADDR_SIZE-1:0] sram_a,
  output logic [WORD_SIZE-1:0] sram_d,
  output logic                 sram_wen,
  input  logic [WORD_SIZE-1:0] sram_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Counter counts down to zero; loading WAIT_CYCLES-1 gives exactly
  // WAIT_CYCLES access cycles, and a load of 0 is never decremented.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_accept;
  logic                   w_access_done;
  logic [3:0]             r_cnt;
  logic                   r_we;
  logic                   r_wen;
  logic                   r_rsp_valid;
  logic                   r_rsp_we;
  logic [WORD_SIZE-1:0]   r_rdata;
  logic [ADDR_SIZE-1:0]   r_a;
  logic [WORD_SIZE-1:0]   r_d;

  assign req_ready = (r_state == IDLE) && !rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_we    = r_rsp_we;
  assign rsp_rdata = r_rdata;
  assign sram_a    = r_a;
  assign sram_d    = r_d;
  assign sram_wen  = r_wen;

  // Next-state logic: accept only in IDLE outside reset, leave ACCESS when the counter is spent.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_access_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && !rst) begin
          w_accept    = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP:  w_state_nxt = ACCESS;
      ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_access_done = 1'b1;
          w_state_nxt   = HOLD;
        end
      end
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, SRAM pin and response registers; reset clears A/D only once WEN is already high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wen       <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rdata     <= '0;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      if (r_wen) begin
        r_a <= '0;
        r_d <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_wen       <= !((w_state_nxt == ACCESS) && r_we);
      r_rsp_valid <= (w_state_nxt == HOLD);
      if (w_accept) begin
        r_a  <= req_addr;
        r_d  <= req_wdata;
        r_we <= req_we;
      end
      if (r_state == SETUP) begin
        r_cnt <= CNT_LOAD;
      end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access_done) begin
        r_rsp_we <= r_we;
        if (!r_we) begin
          r_rdata <= sram_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl with two instances,
// WAIT_CYCLES = 1 (u_dut0) and WAIT_CYCLES = 4 (u_dut1), each driving a
// behavioural SRAM with asynchronous read.
module tb_sram_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_we;
  logic [7:0] req_addr  [2];
  logic [3:0] req_wdata [2];
  logic [1:0] rsp_valid;
  logic [1:0] rsp_we;
  logic [3:0] rsp_rdata [2];
  logic [7:0] sram_a    [2];
  logic [3:0] sram_d    [2];
  logic [1:0] sram_wen;
  logic [3:0] sram_q    [2];

  logic [3:0] mem0 [256];
  logic [3:0] mem1 [256];
  logic [3:0] ref_mem [2][256];
  logic [3:0] last_rd [2];
  longint     last_acc [2];

  typedef struct {
    logic       we;
    logic [3:0] rd;
    longint     t;
  } exp_t;
  exp_t sb0 [$];
  exp_t sb1 [$];

  int   n_chk;
  int   n_pass;
  bit   mon_on;
  logic [1:0] wen_prev;
  logic [7:0] a_prev [2];
  logic [3:0] d_prev [2];

  sram_ctrl #(.ADDR_SIZE(8), .WORD_SIZE(4), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_we(rsp_we[0]), .rsp_rdata(rsp_rdata[0]),
    .sram_a(sram_a[0]), .sram_d(sram_d[0]), .sram_wen(sram_wen[0]), .sram_q(sram_q[0])
  );

  sram_ctrl #(.ADDR_SIZE(8), .WORD_SIZE(4), .WAIT_CYCLES(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_we(rsp_we[1]), .rsp_rdata(rsp_rdata[1]),
    .sram_a(sram_a[1]), .sram_d(sram_d[1]), .sram_wen(sram_wen[1]), .sram_q(sram_q[1])
  );

  // Behavioural SRAMs: asynchronous read, write on every edge with WEN low.
  assign sram_q[0] = mem0[sram_a[0]];
  assign sram_q[1] = mem1[sram_a[1]];

  always @(posedge clk) begin
    if (sram_wen[0] === 1'b0) mem0[sram_a[0]] <= sram_d[0];
    if (sram_wen[1] === 1'b0) mem1[sram_a[1]] <= sram_d[1];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wc(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Response scoreboard plus the pins-hold-while-WEN-low property.
  task automatic mon(input int k);
    exp_t e;
    if (mon_on) begin
      if (rsp_valid[k] === 1'b1) begin
        if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
          chk("rsp_latency", 32'($time), 32'(e.t));
          chk("rsp_we", {31'd0, rsp_we[k]}, {31'd0, e.we});
          chk("rsp_rdata", {28'd0, rsp_rdata[k]}, {28'd0, e.rd});
        end
      end
      if (!(wen_prev[k] && sram_wen[k]))
        chk("pins_hold_wen_low", {20'd0, sram_a[k], sram_d[k]}, {20'd0, a_prev[k], d_prev[k]});
    end
    wen_prev[k] = sram_wen[k];
    a_prev[k]   = sram_a[k];
    d_prev[k]   = sram_d[k];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Present one request (caller sits at a negedge), wait for ready, then watch SETUP..HOLD.
  task automatic issue(input int k, input logic we, input logic [7:0] addr,
                       input logic [3:0] wd, input bit toggle);
    int     n;
    int     wl;
    longint tA;
    exp_t   e;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    req_valid[k] = 1'b1;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", 32'(n), 32'd0);
      return;
    end
    @(posedge clk);
    tA = $time;
    if (last_acc[k] != 0)
      chk("accept_spacing_ok", {31'd0, (tA - last_acc[k]) >= longint'((wc(k) + 3) * 10)}, 32'd1);
    last_acc[k] = tA;
    e.we = we;
    if (we) begin
      ref_mem[k][addr] = wd;
      e.rd = last_rd[k];
    end else begin
      last_rd[k] = ref_mem[k][addr];
      e.rd = last_rd[k];
    end
    e.t = tA + longint'((wc(k) + 1) * 10 + 5);
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    wl = 0;
    for (int c = 0; c < wc(k) + 2; c++) begin
      @(negedge clk);
      if (sram_wen[k] === 1'b0) wl++;
      chk("sram_a_stable", {24'd0, sram_a[k]}, {24'd0, addr});
      if (we) chk("sram_d_stable", {28'd0, sram_d[k]}, {28'd0, wd});
      if (toggle) begin
        req_addr[k]  = 8'($urandom);
        req_wdata[k] = 4'($urandom);
      end
    end
    chk("wen_low_cycles", 32'(wl), we ? 32'(wc(k)) : 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; mon_on = 1'b0;
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00;
    for (int k = 0; k < 2; k++) begin
      req_addr[k] = 8'h00; req_wdata[k] = 4'h0;
      last_rd[k] = 4'h0; last_acc[k] = 0;
      for (int i = 0; i < 256; i++) ref_mem[k][i] = 4'h0;
    end
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 4'h0;
      mem1[i] = 4'h0;
    end

    // Reset held three edges: idle pin state, no ready.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_wen", {31'd0, sram_wen[k]}, 32'd1);
      chk("rst_a", {24'd0, sram_a[k]}, 32'd0);
      chk("rst_d", {28'd0, sram_d[k]}, 32'd0);
      chk("rst_ready", {31'd0, req_ready[k]}, 32'd0);
      chk("rst_rsp", {26'd0, rsp_valid[k], rsp_we[k], rsp_rdata[k]}, 32'd0);
    end
    // A request presented during reset must be ignored.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h55; req_wdata[0] = 4'h9;
    @(posedge clk); #1;
    chk("rst_no_accept_a", {24'd0, sram_a[0]}, 32'd0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst0", {31'd0, req_ready[0]}, 32'd1);
    chk("ready_after_rst1", {31'd0, req_ready[1]}, 32'd1);
    mon_on = 1'b1;
    @(negedge clk);

    // WAIT_CYCLES = 1: write then read back.
    issue(0, 1'b1, 8'h3C, 4'hA, 1'b0);
    issue(0, 1'b0, 8'h3C, 4'h0, 1'b0);
    req_valid[0] = 1'b0;

    // WAIT_CYCLES = 4: write then read back.
    issue(1, 1'b1, 8'hFF, 4'h5, 1'b0);
    issue(1, 1'b0, 8'hFF, 4'h0, 1'b0);
    req_valid[1] = 1'b0;

    // Back-to-back with req_valid held high, address extremes.
    issue(0, 1'b1, 8'h00, 4'h1, 1'b0);
    issue(0, 1'b1, 8'hFF, 4'hE, 1'b0);
    issue(0, 1'b0, 8'h00, 4'h0, 1'b0);
    issue(0, 1'b0, 8'hFF, 4'h0, 1'b0);
    req_valid[0] = 1'b0;

    // Inputs toggled while busy must not disturb the transaction.
    issue(0, 1'b1, 8'h22, 4'h3, 1'b1);
    issue(0, 1'b0, 8'h22, 4'h0, 1'b1);
    req_valid[0] = 1'b0;
    drain();

    // Abort: reset in the write ACCESS cycle.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h10; req_wdata[0] = 4'h7;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("abort_in_access_wen", {31'd0, sram_wen[0]}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_wen_rises", {31'd0, sram_wen[0]}, 32'd1);
    chk("abort_a_holds", {24'd0, sram_a[0]}, 32'h10);
    @(posedge clk); #1;
    chk("abort_a_clear", {24'd0, sram_a[0]}, 32'd0);
    chk("abort_d_clear", {28'd0, sram_d[0]}, 32'd0);
    ref_mem[0][8'h10] = 4'h7;
    last_rd[0] = 4'h0;
    last_rd[1] = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
    end

    // Recovery after abort.
    issue(0, 1'b0, 8'h3C, 4'h0, 1'b0);
    req_valid[0] = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
